// File: rtl/bus_wr_capture_pkg.sv
// Shared definitions for the bus write capture block: bus strobe polarities,
// detector state encodings and a width helper.
package bus_wr_capture_pkg;

  // The Orion bus strobes are active-low.
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

  localparam int DROP_CNT_W = 8;

  typedef enum logic [2:0] {
    DET_IDLE  = 3'd0,
    DET_ARM   = 3'd1,
    DET_CAPT  = 3'd2,
    DET_HOLD  = 3'd3,
    DET_REARM = 3'd4
  } det_state_t;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_wr_capture_cap_fifo.sv
// Single-clock show-ahead FIFO. The head entry is visible on rd_data whenever
// empty is low. A push while full is accepted only if a pop happens in the
// same cycle; otherwise it is ignored and the caller accounts for the drop.
module cap_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bus_wr_capture.sv
// Orion CPU bus write snooper. Synchronises the asynchronous bus into the
// SDRAM clock domain, detects each write strobe once (rejecting one-cycle
// glitches), filters memory writes through programmable address windows,
// optionally captures I/O writes, and queues the result for the SDRAM side.
//
// Detector states:
//   state     | meaning
//   DET_IDLE  | waiting for a write strobe
//   DET_ARM   | strobe seen for one cycle, confirming it is not a glitch
//   DET_CAPT  | strobe confirmed, latch address/data/type and match windows
//   DET_HOLD  | entry taken, waiting for the strobe to go away
//   DET_REARM | strobe gone for one cycle, confirming release
module bus_wr_capture
  import bus_wr_capture_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int N_WIN       = 2,
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_wr_n,
  input  logic                      i_mreq_n,
  input  logic                      i_iorq_n,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]         i_data,
  input  logic [N_WIN-1:0]          i_win_en,
  input  logic [N_WIN*ADDR_W-1:0]   i_win_base,
  input  logic [N_WIN*ADDR_W-1:0]   i_win_mask,
  input  logic                      i_io_en,
  input  logic                      i_clr_ovf,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [ADDR_W-1:0]         o_addr,
  output logic [DATA_W-1:0]         o_data,
  output logic [idx_w(N_WIN)-1:0]   o_win,
  output logic                      o_is_io,
  output logic [FIFO_AW:0]          o_level,
  output logic                      o_overflow,
  output logic [DROP_CNT_W-1:0]     o_drop_cnt
);

  localparam int WIN_W    = idx_w(N_WIN);
  localparam int ENT_W    = 1 + WIN_W + ADDR_W + DATA_W;
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] mreq_sync;
  logic [SYNC_STAGES-1:0] iorq_sync;
  logic [ADDR_W-1:0]      a_sync [SYNC_STAGES];
  logic [DATA_W-1:0]      d_sync [SYNC_STAGES];

  logic [ADDR_W-1:0]      a_s;
  logic [DATA_W-1:0]      d_s;
  logic                   mem_wr;
  logic                   io_wr;
  logic                   bus_act;
  logic                   last_mem;

  logic [SETTLE_W-1:0]    settle_cnt;
  logic                   quiet;

  det_state_t             state;
  det_state_t             state_nxt;
  logic                   capt;

  logic                   hit_any;
  logic [WIN_W-1:0]       hit_idx;
  logic [ADDR_W-1:0]      io_addr;

  logic                   cap_vld;
  logic                   cap_keep;
  logic                   cap_io;
  logic [WIN_W-1:0]       cap_win;
  logic [ADDR_W-1:0]      cap_addr;
  logic [DATA_W-1:0]      cap_data;

  logic                   push_req;
  logic                   pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENT_W-1:0]       head;

  assign a_s     = a_sync[SYNC_STAGES-1];
  assign d_s     = d_sync[SYNC_STAGES-1];
  assign mem_wr  = (mreq_sync[SYNC_STAGES-1] == STROBE_ACTIVE) && (wr_sync[SYNC_STAGES-1] == STROBE_ACTIVE);
  assign io_wr   = (iorq_sync[SYNC_STAGES-1] == STROBE_ACTIVE) && (wr_sync[SYNC_STAGES-1] == STROBE_ACTIVE) && i_io_en;
  assign bus_act = mem_wr || io_wr;

  // Synchroniser chains for strobes, address and data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_sync   <= {SYNC_STAGES{STROBE_IDLE}};
      mreq_sync <= {SYNC_STAGES{STROBE_IDLE}};
      iorq_sync <= {SYNC_STAGES{STROBE_IDLE}};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_sync[i] <= '0;
        d_sync[i] <= '0;
      end
    end else begin
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], i_wr_n};
      mreq_sync <= {mreq_sync[SYNC_STAGES-2:0], i_mreq_n};
      iorq_sync <= {iorq_sync[SYNC_STAGES-2:0], i_iorq_n};
      a_sync[0] <= i_addr;
      d_sync[0] <= i_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_sync[i] <= a_sync[i-1];
        d_sync[i] <= d_sync[i-1];
      end
    end
  end

  // After reset the synchronisers show idle levels that may not reflect the
  // bus. Wait for the chain to refill, then require a genuinely idle bus
  // before the detector may arm, so a strobe held across reset is ignored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      settle_cnt <= SETTLE_W'(SYNC_STAGES);
      quiet      <= 1'b0;
    end else if (settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end else if (!bus_act) begin
      quiet <= 1'b1;
    end
  end

  // Detector state register and strobe-type memory. The type is remembered
  // from the last active sample so a strobe released during CAPT is still
  // classified correctly.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= DET_IDLE;
      last_mem <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus_act) last_mem <= mem_wr;
    end
  end

  // Detector next-state logic.
  always_comb begin
    state_nxt = state;
    capt      = 1'b0;
    case (state)
      DET_IDLE:  if (bus_act && quiet) state_nxt = DET_ARM;
      DET_ARM:   state_nxt = bus_act ? DET_CAPT : DET_IDLE;
      DET_CAPT: begin
        capt      = 1'b1;
        state_nxt = DET_HOLD;
      end
      DET_HOLD:  if (!bus_act) state_nxt = DET_REARM;
      DET_REARM: state_nxt = bus_act ? DET_HOLD : DET_IDLE;
      default:   state_nxt = DET_IDLE;
    endcase
  end

  // Window match, lowest index wins (scan from the top so lower ones overwrite).
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = N_WIN - 1; k >= 0; k--) begin
      if (i_win_en[k] &&
          (((a_s ^ i_win_base[k*ADDR_W +: ADDR_W]) & i_win_mask[k*ADDR_W +: ADDR_W]) == '0)) begin
        hit_any = 1'b1;
        hit_idx = WIN_W'(k);
      end
    end
  end

  // I/O writes keep only the low address byte.
  always_comb begin
    io_addr      = '0;
    io_addr[7:0] = a_s[7:0];
  end

  // Capture and match register: loaded in CAPT, presented to the FIFO next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cap_vld  <= 1'b0;
      cap_keep <= 1'b0;
      cap_io   <= 1'b0;
      cap_win  <= '0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      cap_vld <= capt;
      if (capt) begin
        cap_keep <= last_mem ? hit_any : 1'b1;
        cap_io   <= !last_mem;
        cap_win  <= last_mem ? hit_idx : '0;
        cap_addr <= last_mem ? a_s : io_addr;
        cap_data <= d_s;
      end
    end
  end

  assign push_req = cap_vld && cap_keep;
  assign pop      = o_valid && i_ready;
  assign drop     = push_req && fifo_full && !pop;

  cap_fifo #(
    .W  (ENT_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_reset),
    .push    (push_req),
    .pop     (pop),
    .wr_data ({cap_io, cap_win, cap_addr, cap_data}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  // Head fields are forced to zero while empty so all outputs read 0 after reset.
  assign o_valid = !fifo_empty;
  assign o_is_io = o_valid ? head[ENT_W-1] : 1'b0;
  assign o_win   = o_valid ? head[ADDR_W+DATA_W +: WIN_W] : '0;
  assign o_addr  = o_valid ? head[DATA_W +: ADDR_W] : '0;
  assign o_data  = o_valid ? head[DATA_W-1:0] : '0;

  // Overflow flag and saturating drop counter; a clear beats a same-cycle drop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_wr_capture.sv
// Bench for bus_wr_capture: a table of single-write vectors plus hand-written
// sequences for latency, overflow and reset. Expected entries go into a
// scoreboard queue when the write is driven and are checked on every pop.
module tb_bus_wr_capture;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int NW  = 2;
  localparam int FAW = 4;
  localparam int SS  = 2;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_wr_n = 1'b1;
  logic            i_mreq_n = 1'b1;
  logic            i_iorq_n = 1'b1;
  logic [AW-1:0]   i_addr = '0;
  logic [DW-1:0]   i_data = '0;
  logic [NW-1:0]   i_win_en = '0;
  logic [NW*AW-1:0] i_win_base = '0;
  logic [NW*AW-1:0] i_win_mask = '0;
  logic            i_io_en = 1'b0;
  logic            i_clr_ovf = 1'b0;
  logic            i_ready = 1'b0;
  logic            o_valid;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_data;
  logic [0:0]      o_win;
  logic            o_is_io;
  logic [FAW:0]    o_level;
  logic            o_overflow;
  logic [7:0]      o_drop_cnt;

  bus_wr_capture #(
    .ADDR_W(AW), .DATA_W(DW), .N_WIN(NW), .FIFO_AW(FAW), .SYNC_STAGES(SS)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wr_n(i_wr_n), .i_mreq_n(i_mreq_n),
    .i_iorq_n(i_iorq_n), .i_addr(i_addr), .i_data(i_data), .i_win_en(i_win_en),
    .i_win_base(i_win_base), .i_win_mask(i_win_mask), .i_io_en(i_io_en),
    .i_clr_ovf(i_clr_ovf), .o_valid(o_valid), .i_ready(i_ready), .o_addr(o_addr),
    .o_data(o_data), .o_win(o_win), .o_is_io(o_is_io), .o_level(o_level),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          win;
    logic          io;
  } ent_t;

  typedef struct {
    string         name;
    logic          io;
    logic          io_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            hold;
    logic [1:0]    en;
    logic [AW-1:0] b0, m0, b1, m1;
    logic          capt;
    logic [AW-1:0] xaddr;
    logic          xwin;
  } vec_t;

  ent_t sb[$];
  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Scoreboard check on every accepted pop.
  always @(negedge clk) begin
    ent_t e;
    if (!i_reset && o_valid && i_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got addr=%h data=%h win=%0d io=%0d, required no entry",
                 o_addr, o_data, o_win, o_is_io);
      end else begin
        e = sb.pop_front();
        if ({o_addr, o_data, o_win, o_is_io} !== {e.addr, e.data, e.win, e.io}) begin
          n_err++;
          $display("FAIL pop_entry: got addr=%h data=%h win=%0d io=%0d, required addr=%h data=%h win=%0d io=%0d",
                   o_addr, o_data, o_win, o_is_io, e.addr, e.data, e.win, e.io);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_on(input logic io);
    if (io) i_iorq_n = 1'b0;
    else    i_mreq_n = 1'b0;
    i_wr_n = 1'b0;
  endtask

  task automatic strobe_off();
    i_wr_n   = 1'b1;
    i_mreq_n = 1'b1;
    i_iorq_n = 1'b1;
  endtask

  task automatic bus_write(input logic io, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int hold, input int gap);
    i_addr = a;
    i_data = d;
    tick(1);
    strobe_on(io);
    tick(hold);
    strobe_off();
    tick(gap);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !o_valid) break;
      tick(1);
    end
    chk({name, "_drained"}, {30'd0, sb.size() == 0, o_valid}, 32'h2);
    chk({name, "_level"}, 32'(o_level), 32'h0);
  endtask

  task automatic set_win(input logic [1:0] en, input logic [AW-1:0] b0, input logic [AW-1:0] m0,
                         input logic [AW-1:0] b1, input logic [AW-1:0] m1);
    i_win_en   = en;
    i_win_base = {b1, b0};
    i_win_mask = {m1, m0};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    ent_t e;

    vt.push_back('{"mem_win0",     0, 0, 16'hC123, 8'h5A,  4, 2'b01, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 1, 16'hC123, 0});
    vt.push_back('{"glitch_1clk",  0, 0, 16'hC123, 8'hA5,  1, 2'b01, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 0, 16'h0000, 0});
    vt.push_back('{"long_40clk",   0, 0, 16'hC124, 8'h3C, 40, 2'b01, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 1, 16'hC124, 0});
    vt.push_back('{"miss_both",    0, 0, 16'h1234, 8'h77,  4, 2'b11, 16'hC000, 16'hC000, 16'h8000, 16'hC000, 0, 16'h0000, 0});
    vt.push_back('{"overlap_w0",   0, 0, 16'hC155, 8'h66,  4, 2'b11, 16'hC000, 16'hC000, 16'hC100, 16'hFF00, 1, 16'hC155, 0});
    vt.push_back('{"only_w1",      0, 0, 16'hC155, 8'h67,  4, 2'b10, 16'hC000, 16'hC000, 16'hC100, 16'hFF00, 1, 16'hC155, 1});
    vt.push_back('{"all_disabled", 0, 0, 16'hC155, 8'h68,  4, 2'b00, 16'hC000, 16'hC000, 16'hC100, 16'hFF00, 0, 16'h0000, 0});
    vt.push_back('{"io_off",       1, 0, 16'h00F8, 8'h11,  4, 2'b11, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 0, 16'h0000, 0});
    vt.push_back('{"io_on",        1, 1, 16'h00F8, 8'h11,  4, 2'b11, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 1, 16'h00F8, 0});
    vt.push_back('{"io_zext",      1, 1, 16'hAB37, 8'h22,  4, 2'b00, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 1, 16'h0037, 0});
    vt.push_back('{"exact_w1",     0, 0, 16'h4321, 8'h99,  4, 2'b11, 16'h0000, 16'hFFFF, 16'h4321, 16'hFFFF, 1, 16'h4321, 1});
    vt.push_back('{"mask0_all",    0, 0, 16'h1357, 8'hEE,  3, 2'b01, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1357, 0});
    vt.push_back('{"mem_io_en",    0, 1, 16'hC200, 8'h01,  4, 2'b01, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 1, 16'hC200, 0});

    tick(3);
    @(negedge clk);
    i_reset = 1'b0;
    tick(1);
    chk("reset_valid",    32'(o_valid),    32'h0);
    chk("reset_level",    32'(o_level),    32'h0);
    chk("reset_overflow", 32'(o_overflow), 32'h0);
    chk("reset_drop_cnt", 32'(o_drop_cnt), 32'h0);
    chk("reset_addr",     32'(o_addr),     32'h0);
    tick(8);

    // Latency from driving the strobe to o_valid.
    set_win(2'b01, 16'hC000, 16'hC000, 16'h0000, 16'h0000);
    i_addr = 16'hC321;
    i_data = 8'h4B;
    tick(1);
    sb.push_back('{16'hC321, 8'h4B, 1'b0, 1'b0});
    strobe_on(1'b0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(SS + 4));
    strobe_off();
    i_ready = 1'b1;
    tick(6);
    drain("latency");

    // Table of single writes.
    foreach (vt[v]) begin
      set_win(vt[v].en, vt[v].b0, vt[v].m0, vt[v].b1, vt[v].m1);
      i_io_en = vt[v].io_en;
      i_ready = 1'b1;
      if (vt[v].capt) sb.push_back('{vt[v].xaddr, vt[v].data, vt[v].xwin, vt[v].io});
      bus_write(vt[v].io, vt[v].addr, vt[v].data, vt[v].hold, 10);
      drain(vt[v].name);
    end
    i_io_en = 1'b0;

    // Overflow: 19 writes into a 16-deep FIFO with no consumer.
    set_win(2'b01, 16'hC000, 16'hC000, 16'h0000, 16'h0000);
    i_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (i < 16) sb.push_back('{16'hC000 + 16'(i), 8'(i), 1'b0, 1'b0});
      bus_write(1'b0, 16'hC000 + 16'(i), 8'(i), 3, 6);
    end
    tick(4);
    chk("ovf_level",    32'(o_level),    32'd16);
    chk("ovf_flag",     32'(o_overflow), 32'h1);
    chk("ovf_drop_cnt", 32'(o_drop_cnt), 32'd3);

    // Push and pop in the same cycle while full.
    i_addr = 16'hC0AA;
    i_data = 8'hAA;
    tick(1);
    sb.push_back('{16'hC0AA, 8'hAA, 1'b0, 1'b0});
    strobe_on(1'b0);
    tick(SS + 3);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    chk("full_pushpop_level", 32'(o_level),    32'd16);
    chk("full_pushpop_drop",  32'(o_drop_cnt), 32'd3);
    strobe_off();
    tick(4);
    i_clr_ovf = 1'b1;
    tick(1);
    i_clr_ovf = 1'b0;
    chk("clr_overflow", 32'(o_overflow), 32'h0);
    chk("clr_drop_cnt", 32'(o_drop_cnt), 32'h0);
    i_ready = 1'b1;
    drain("ovf");

    // Reset with entries queued and a strobe held low.
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(1'b0, 16'hC010 + 16'(i), 8'h80 + 8'(i), 3, 6);
    tick(2);
    chk("pre_reset_level", 32'(o_level), 32'd5);
    i_addr = 16'hC077;
    i_data = 8'h7E;
    tick(1);
    strobe_on(1'b0);
    tick(3);
    #2 i_reset = 1'b1;
    #3;
    chk("in_reset_valid", 32'(o_valid), 32'h0);
    chk("in_reset_level", 32'(o_level), 32'h0);
    @(negedge clk);
    i_reset = 1'b0;
    tick(1);
    chk("post_reset_valid", 32'(o_valid), 32'h0);
    chk("post_reset_level", 32'(o_level), 32'h0);
    i_ready = 1'b1;
    tick(30);
    chk("held_strobe_level", 32'(o_level), 32'h0);
    strobe_off();
    tick(5);
    sb.push_back('{16'hC077, 8'h7E, 1'b0, 1'b0});
    bus_write(1'b0, 16'hC077, 8'h7E, 4, 10);
    drain("rearm");

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
